idli_ibuf_m: RTL and testbench

IDLI_IBUF_M -- requirements
Module: idli_ibuf_m

---
 rtl/idli_pkg.sv | 15 +
 rtl/idli_ibuf_if.sv | 11 +
 rtl/idli_nibble_fifo_m.sv | 50 +++++
 rtl/idli_ibuf_m.sv | 134 +++++++++++++
 tb/tb_idli_ibuf_m.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/idli_pkg.sv
// Shared types for the instruction buffer: nibble type, issue FSM states and beats per instruction.
package idli_pkg;

    localparam int IBUF_BEATS = 4;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT1,
        ST_BEAT2,
        ST_BEAT3
    } ibuf_state_t;

endpackage

// File: rtl/idli_ibuf_if.sv
// Nibble handshake between the memory interface (master) and the instruction buffer (slave).
interface idli_ibuf_if;
    import idli_pkg::*;

    nibble_t i_ibuf_sqi;
    logic    i_ibuf_sqi_vld;
    logic    o_ibuf_sqi_rdy;

    modport master (output i_ibuf_sqi, output i_ibuf_sqi_vld, input  o_ibuf_sqi_rdy);
    modport slave  (input  i_ibuf_sqi, input  i_ibuf_sqi_vld, output o_ibuf_sqi_rdy);
endinterface

// File: rtl/idli_nibble_fifo_m.sv
// Circular nibble FIFO with wrap-bit pointers; i_clr drops everything left after this cycle's pop.
module idli_nibble_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  nibble_t                  i_wdata,
    input  logic                     i_pop,
    input  logic                     i_clr,
    output nibble_t                  o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    nibble_t       mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, i_pop};
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, i_push};
        if (i_clr) begin
            wr_ptr_d = rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
        end
    end

    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign o_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/idli_ibuf_m.sv
// Instruction buffer: queues nibbles and issues 4-beat instructions with PC tracking and flush.
// Optional starvation counter enabled by defining IDLI_IBUF_STARVE_CNT_EN.
module idli_ibuf_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          i_dcd_gck,
    input  logic          i_dcd_rst_n,
    idli_ibuf_if.slave    sqi_if,
    input  logic          i_ibuf_stall,
    input  logic          i_ibuf_flush,
    input  logic [15:0]   i_ibuf_flush_pc,
    output nibble_t       o_ibuf_enc,
    output logic          o_ibuf_enc_vld,
    output logic [15:0]   o_ibuf_pc,
    output logic [15:0]   o_ibuf_starve_cnt
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] BEATS_CNT = (AW+1)'(IBUF_BEATS);

    if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("idli_ibuf_m: DEPTH must be a power of two and at least 8");
    end

    ibuf_state_t  state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  out_pc_q, out_pc_d;
    logic         fl_pend_q, fl_pend_d;
    logic [15:0]  fl_pc_q, fl_pc_d;

    nibble_t      head;
    logic [AW:0]  count;
    logic         idle, last, start, beat, push, apply_fl;
    logic [15:0]  fl_tgt;

    idli_nibble_fifo_m #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_dcd_gck),
        .i_rst_n (i_dcd_rst_n),
        .i_push  (push),
        .i_wdata (sqi_if.i_ibuf_sqi),
        .i_pop   (beat),
        .i_clr   (apply_fl),
        .o_head  (head),
        .o_count (count)
    );

    always_comb begin
        idle     = (state_q == ST_IDLE);
        last     = (state_q == ST_BEAT3);
        start    = idle && (count >= BEATS_CNT) && !i_ibuf_stall && !i_ibuf_flush && !fl_pend_q;
        beat     = start || !idle;
        // A flush raised during beats waits for BEAT3; one arriving in BEAT3 itself takes effect there.
        apply_fl = (idle && i_ibuf_flush) || (last && (i_ibuf_flush || fl_pend_q));
        fl_tgt   = i_ibuf_flush ? i_ibuf_flush_pc : fl_pc_q;
        push     = sqi_if.i_ibuf_sqi_vld && sqi_if.o_ibuf_sqi_rdy && !i_ibuf_flush && !fl_pend_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_BEAT1;
            ST_BEAT1: state_d = ST_BEAT2;
            ST_BEAT2: state_d = ST_BEAT3;
            ST_BEAT3: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        if (start) begin
            out_pc_d = pc_q;
            pc_d     = pc_q + 16'd1;
        end
        if (apply_fl) begin
            pc_d = fl_tgt;
        end

        fl_pend_d = fl_pend_q;
        fl_pc_d   = fl_pc_q;
        if (last) begin
            fl_pend_d = 1'b0;
        end else if (!idle && i_ibuf_flush) begin
            fl_pend_d = 1'b1;
            fl_pc_d   = i_ibuf_flush_pc;
        end
    end

    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            out_pc_q  <= '0;
            fl_pend_q <= 1'b0;
            fl_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            out_pc_q  <= out_pc_d;
            fl_pend_q <= fl_pend_d;
            fl_pc_q   <= fl_pc_d;
        end
    end

    assign sqi_if.o_ibuf_sqi_rdy = (count < FULL_CNT);
    assign o_ibuf_enc            = beat ? head : 4'h0;
    assign o_ibuf_enc_vld        = beat;
    assign o_ibuf_pc             = out_pc_q;

`ifdef IDLI_IBUF_STARVE_CNT_EN
    logic [15:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (i_ibuf_flush) begin
            starve_d = '0;
        end else if (idle && (count < BEATS_CNT) && !i_ibuf_stall && (starve_q != 16'hFFFF)) begin
            starve_d = starve_q + 16'd1;
        end
    end

    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign o_ibuf_starve_cnt = starve_q;
`else
    assign o_ibuf_starve_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_idli_ibuf_m.sv
// Randomized bench for idli_ibuf_m against a queue-based reference model of the issue rules.
module tb_idli_ibuf_m;
    import idli_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] fpc = '0;
    nibble_t     enc;
    logic        enc_vld;
    logic [15:0] pc;
    logic [15:0] starve;

    idli_ibuf_if sqi_if ();

    idli_ibuf_m #(.DEPTH(DEPTH)) dut (
        .i_dcd_gck         (clk),
        .i_dcd_rst_n       (rst_n),
        .sqi_if            (sqi_if),
        .i_ibuf_stall      (stall),
        .i_ibuf_flush      (flush),
        .i_ibuf_flush_pc   (fpc),
        .o_ibuf_enc        (enc),
        .o_ibuf_enc_vld    (enc_vld),
        .o_ibuf_pc         (pc),
        .o_ibuf_starve_cnt (starve)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: instruction stream as a queue, progress as beats remaining.
    nibble_t     q[$];
    int          beats_left;
    bit          pend;
    logic [15:0] pend_pc, pc_next, pc_out, starve_m;

    function automatic logic [15:0] exp_starve();
`ifdef IDLI_IBUF_STARVE_CNT_EN
        return starve_m;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        beats_left = 0;
        pend       = 0;
        pend_pc    = '0;
        pc_next    = '0;
        pc_out     = '0;
        starve_m   = '0;
    endtask

    task automatic step(input bit v, input nibble_t d, input bit st, input bit fl, input logic [15:0] tgt);
        bit      rdy_m, start_m, beat_m, push_m;
        nibble_t enc_m;
        sqi_if.i_ibuf_sqi     = d;
        sqi_if.i_ibuf_sqi_vld = v;
        stall = st;
        flush = fl;
        fpc   = tgt;
        rdy_m   = q.size() < DEPTH;
        start_m = (beats_left == 0) && (q.size() >= IBUF_BEATS) && !st && !fl;
        beat_m  = start_m || (beats_left > 0);
        enc_m   = beat_m ? q[0] : 4'h0;
        @(negedge clk);
        check_eq("rdy", 32'(sqi_if.o_ibuf_sqi_rdy), 32'(rdy_m));
        check_eq("enc_vld", 32'(enc_vld), 32'(beat_m));
        check_eq("enc", 32'(enc), 32'(enc_m));
        check_eq("pc", 32'(pc), 32'(pc_out));
        check_eq("starve", 32'(starve), 32'(exp_starve()));
        @(posedge clk);
        push_m = v && rdy_m && !fl && !pend;
        if (fl) starve_m = '0;
        else if (beats_left == 0 && q.size() < IBUF_BEATS && !st && starve_m != 16'hFFFF) starve_m++;
        if (beat_m) void'(q.pop_front());
        if (start_m) begin
            pc_out     = pc_next;
            pc_next    = pc_next + 16'd1;
            beats_left = IBUF_BEATS - 1;
        end else if (beats_left > 0) begin
            if (beats_left == 1) begin
                if (fl || pend) begin
                    q.delete();
                    pc_next = fl ? tgt : pend_pc;
                    pend    = 0;
                end
            end else if (fl) begin
                pend    = 1;
                pend_pc = tgt;
            end
            beats_left--;
        end else if (fl) begin
            q.delete();
            pc_next = tgt;
        end
        if (push_m) q.push_back(d);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && !(beats_left == 0 && q.size() < IBUF_BEATS); i++)
            step(0, 4'h0, 0, 0, 16'h0);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 16'h0);
    endtask

    initial begin
        model_reset();
        sqi_if.i_ibuf_sqi     = 4'h0;
        sqi_if.i_ibuf_sqi_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vld", 32'(enc_vld), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_starve", 32'(starve), 32'd0);
        check_eq("rst_rdy", 32'(sqi_if.o_ibuf_sqi_rdy), 32'd1);
        rst_n = 1'b1;

        // Idle and empty for 10 cycles, then reset clears the counter.
        idle_steps(10);
`ifdef IDLI_IBUF_STARVE_CNT_EN
        check_eq("starve10", 32'(starve), 32'd10);
`else
        check_eq("starve_off", 32'(starve), 32'd0);
`endif
        rst_n = 1'b0;
        #1;
        check_eq("starve_rst", 32'(starve), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A,B,C,D then four beats.
        step(1, 4'hA, 0, 0, 16'h0);
        step(1, 4'hB, 0, 0, 16'h0);
        step(1, 4'hC, 0, 0, 16'h0);
        step(1, 4'hD, 0, 0, 16'h0);
        idle_steps(4);
        check_eq("pc_first", 32'(pc), 32'h0000);

        // Continuous feed: four back-to-back instructions.
        for (int i = 0; i < 16; i++) step(1, nibble_t'($urandom), 0, 0, 16'h0);
        drain();
        check_eq("pc_feed", 32'(pc), 32'h0004);

        // Fill to capacity under stall, ninth nibble refused, then release.
        for (int i = 0; i < 9; i++) step(1, nibble_t'(i), 1, 0, 16'h0);
        idle_steps(10);

        // Flush at BEAT1 with five queued.
        for (int i = 0; i < 5; i++) step(1, nibble_t'(4'h5 + i), 1, 0, 16'h0);
        step(0, 4'h0, 0, 0, 16'h0);
        step(0, 4'h0, 0, 1, 16'h1234);
        step(1, 4'hE, 0, 0, 16'h0);
        step(0, 4'h0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) step(1, nibble_t'(4'h1 + i), 0, 0, 16'h0);
        idle_steps(4);
        check_eq("pc_flush", 32'(pc), 32'h1234);

        // PC wraps from 0xFFFF.
        step(0, 4'h0, 0, 1, 16'hFFFF);
        for (int i = 0; i < 8; i++) step(1, nibble_t'($urandom), 0, 0, 16'h0);
        drain();
        check_eq("pc_wrap", 32'(pc), 32'h0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] t;
            t = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 3))) : 16'($urandom);
            step($urandom_range(0, 9) < 7, nibble_t'($urandom),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 39) == 0, t);
        end

        // Reset in the middle of an instruction abandons the remaining beats.
        drain();
        step(0, 4'h0, 0, 1, 16'h0040);
        for (int i = 0; i < 4; i++) step(1, nibble_t'(4'h9), 1, 0, 16'h0);
        step(0, 4'h0, 0, 0, 16'h0);
        check_eq("mid_pc", 32'(pc), 32'h0040);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", 32'(enc_vld), 32'd0);
        check_eq("mid_rst_pc", 32'(pc), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_eq("mid_rst_vld2", 32'(enc_vld), 32'd0);
        rst_n = 1'b1;
        idle_steps(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
